// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Purpose:
//   This is the multi-cycle sequencer for the CPU datapath. It steps each
//   instruction through FETCH, DECODE, EXEC, MEM and WB. It waits on the
//   ready handshakes from instruction memory and data memory, so either
//   memory may have variable latency. An illegal opcode parks the sequencer
//   in a sticky FAULT state. Only reset leaves FAULT.
//
// Optional feature (macro MULTICYCLE_CONTROL_TIMEOUT_EN):
//   When the macro is defined, a wait-cycle counter bounds every memory
//   handshake. If a FETCH or MEM wait lasts TIMEOUT_CYCLES cycles with no
//   ready, the sequencer moves to FAULT. When the macro is undefined, no
//   counter exists and waits are unbounded.
//
// Parameters:
//   TIMEOUT_CYCLES : maximum handshake wait cycles (timeout build only)
//   TIMEOUT_W      : width of the timeout counter
//
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   run               : level input; enables sequencing, sampled at boundaries
//   opcode[5:0]       : opcode field from the instruction register
//   inst_ready        : instruction memory data valid
//   data_ready        : data memory read/write complete
//   inst_rd_en        : instruction fetch request
//   ir_wr_en          : load instruction register
//   pc_wr_en          : update program counter
//   jump_en           : PC source = jump address
//   branch_en         : PC source = branch address (qualified by zero flag)
//   reg_wr_en         : register file write
//   reg_dest          : 1 = rd field, 0 = rt field
//   mem_rd_en         : data memory read
//   mem_wr_en         : data memory write
//   mem_to_reg        : 1 = write-back from memory, 0 = from ALU
//   alu_opcode[1:0]   : 00 add, 01 sub, 10 R-type funct
//   alu_in_sel        : 1 = sign-extended immediate, 0 = register bus 2
//   instr_done        : one-cycle pulse on an instruction's last cycle
//   fault             : sticky illegal-opcode / timeout indication
//   state_dbg[2:0]    : current state encoding
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_W      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic       inst_ready,
  input  logic       data_ready,
  output logic       inst_rd_en,
  output logic       ir_wr_en,
  output logic       pc_wr_en,
  output logic       jump_en,
  output logic       branch_en,
  output logic       reg_wr_en,
  output logic       reg_dest,
  output logic       mem_rd_en,
  output logic       mem_wr_en,
  output logic       mem_to_reg,
  output logic [1:0] alu_opcode,
  output logic       alu_in_sel,
  output logic       instr_done,
  output logic       fault,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd7;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

  // Last wait count before the sequencer declares a handshake timeout.
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0] r_state;
  logic [5:0] r_opcode_q;
  logic [2:0] w_next_state;
  logic [2:0] w_boundary;
  logic       w_timeout;

  // Decode both outputs and the next state from the current state and the
  // latched opcode. DECODE uses the live opcode input because opcode_q only
  // becomes valid on the edge that leaves DECODE.
  logic       w_inst_rd_en, w_ir_wr_en, w_pc_wr_en, w_jump_en, w_branch_en;
  logic       w_reg_wr_en, w_reg_dest, w_mem_rd_en, w_mem_wr_en, w_mem_to_reg;
  logic [1:0] w_alu_opcode;
  logic       w_alu_in_sel, w_instr_done, w_fault;

  // run is sampled only here, on an instruction's last cycle.
  assign w_boundary = run ? S_FETCH : S_IDLE;

`ifdef MULTICYCLE_CONTROL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_wait_cnt;
  logic                 w_waiting;
  logic                 w_entering_wait;

  assign w_waiting = ((r_state == S_FETCH) && !inst_ready) ||
                     ((r_state == S_MEM)   && !data_ready);
  assign w_entering_wait = (w_next_state != r_state) &&
                           ((w_next_state == S_FETCH) || (w_next_state == S_MEM));
  assign w_timeout = w_waiting && (r_wait_cnt == TIMEOUT_LAST);

  // The wait counter clears on entry to a waiting state and counts each
  // cycle that the awaited ready stays low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= {TIMEOUT_W{1'b0}};
    end else if (w_entering_wait) begin
      r_wait_cnt <= {TIMEOUT_W{1'b0}};
    end else if (w_waiting) begin
      r_wait_cnt <= r_wait_cnt + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end
`else
  logic w_unused_cfg;

  assign w_timeout    = 1'b0;
  assign w_unused_cfg = ^TIMEOUT_LAST;
`endif

  // Next-state and control-output decode.
  always_comb begin
    w_next_state = r_state;
    w_inst_rd_en = 1'b0;
    w_ir_wr_en   = 1'b0;
    w_pc_wr_en   = 1'b0;
    w_jump_en    = 1'b0;
    w_branch_en  = 1'b0;
    w_reg_wr_en  = 1'b0;
    w_reg_dest   = 1'b0;
    w_mem_rd_en  = 1'b0;
    w_mem_wr_en  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_opcode = ALU_ADD;
    w_alu_in_sel = 1'b0;
    w_instr_done = 1'b0;
    w_fault      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_IDLE;
        end
      end

      S_FETCH: begin
        w_inst_rd_en = 1'b1;
        if (inst_ready) begin
          w_ir_wr_en   = 1'b1;
          w_pc_wr_en   = 1'b1;
          w_next_state = S_DECODE;
        end else if (w_timeout) begin
          w_next_state = S_FAULT;
        end else begin
          w_next_state = S_FETCH;
        end
      end

      S_DECODE: begin
        case (opcode)
          OP_J: begin
            w_jump_en    = 1'b1;
            w_pc_wr_en   = 1'b1;
            w_instr_done = 1'b1;
            w_next_state = w_boundary;
          end
          OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI: begin
            w_next_state = S_EXEC;
          end
          default: begin
            w_next_state = S_FAULT;
          end
        endcase
      end

      S_EXEC: begin
        case (r_opcode_q)
          OP_R: begin
            w_alu_opcode = ALU_FN;
            w_next_state = S_WB;
          end
          OP_ADDI: begin
            w_alu_in_sel = 1'b1;
            w_next_state = S_WB;
          end
          OP_LW, OP_SW: begin
            w_alu_in_sel = 1'b1;
            w_next_state = S_MEM;
          end
          OP_BEQ: begin
            w_alu_opcode = ALU_SUB;
            w_branch_en  = 1'b1;
            w_pc_wr_en   = 1'b1;
            w_instr_done = 1'b1;
            w_next_state = w_boundary;
          end
          default: begin
            w_next_state = S_FAULT;
          end
        endcase
      end

      S_MEM: begin
        // The address computation stays selected for the whole access.
        w_alu_in_sel = 1'b1;
        case (r_opcode_q)
          OP_LW: begin
            w_mem_rd_en = 1'b1;
            if (data_ready) begin
              w_next_state = S_WB;
            end else if (w_timeout) begin
              w_next_state = S_FAULT;
            end else begin
              w_next_state = S_MEM;
            end
          end
          OP_SW: begin
            w_mem_wr_en = 1'b1;
            if (data_ready) begin
              w_instr_done = 1'b1;
              w_next_state = w_boundary;
            end else if (w_timeout) begin
              w_next_state = S_FAULT;
            end else begin
              w_next_state = S_MEM;
            end
          end
          default: begin
            w_next_state = S_FAULT;
          end
        endcase
      end

      S_WB: begin
        w_reg_wr_en  = 1'b1;
        w_instr_done = 1'b1;
        w_next_state = w_boundary;
        case (r_opcode_q)
          OP_R: begin
            w_reg_dest   = 1'b1;
            w_alu_opcode = ALU_FN;
          end
          OP_LW: begin
            w_mem_to_reg = 1'b1;
            w_alu_in_sel = 1'b1;
          end
          OP_ADDI: begin
            w_alu_in_sel = 1'b1;
          end
          default: begin
            w_reg_wr_en  = 1'b0;
            w_instr_done = 1'b0;
            w_next_state = S_FAULT;
          end
        endcase
      end

      S_FAULT: begin
        w_fault      = 1'b1;
        w_next_state = S_FAULT;
      end

      // Unused encoding (6): treat as a fault so it cannot silently run.
      default: begin
        w_next_state = S_FAULT;
      end
    endcase
  end

  // State register and opcode latch; reset overrides every event.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_opcode_q <= 6'b000000;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) begin
        r_opcode_q <= opcode;
      end else begin
        r_opcode_q <= r_opcode_q;
      end
    end
  end

  assign inst_rd_en = w_inst_rd_en;
  assign ir_wr_en   = w_ir_wr_en;
  assign pc_wr_en   = w_pc_wr_en;
  assign jump_en    = w_jump_en;
  assign branch_en  = w_branch_en;
  assign reg_wr_en  = w_reg_wr_en;
  assign reg_dest   = w_reg_dest;
  assign mem_rd_en  = w_mem_rd_en;
  assign mem_wr_en  = w_mem_wr_en;
  assign mem_to_reg = w_mem_to_reg;
  assign alu_opcode = w_alu_opcode;
  assign alu_in_sel = w_alu_in_sel;
  assign instr_done = w_instr_done;
  assign fault      = w_fault;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// This bench drives a per-cycle table of directed vectors through
// multicycle_control. Each record holds that cycle's inputs and the expected
// packed outputs during that cycle. After the table, hand-written sequences
// cover a long data-memory wait, the timeout (when the macro is compiled in),
// and a reset that arrives mid-wait.
//
// Packed output order, bit 17 down to bit 0:
//   inst_rd_en, ir_wr_en, pc_wr_en, jump_en, branch_en, reg_wr_en, reg_dest,
//   mem_rd_en, mem_wr_en, mem_to_reg, alu_opcode[1:0], alu_in_sel,
//   instr_done, fault, state_dbg[2:0]
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic       run;
  logic [5:0] opcode;
  logic       inst_ready;
  logic       data_ready;
  logic       inst_rd_en, ir_wr_en, pc_wr_en, jump_en, branch_en;
  logic       reg_wr_en, reg_dest, mem_rd_en, mem_wr_en, mem_to_reg;
  logic [1:0] alu_opcode;
  logic       alu_in_sel, instr_done, fault;
  logic [2:0] state_dbg;

  int total;
  int bad;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .opcode     (opcode),
    .inst_ready (inst_ready),
    .data_ready (data_ready),
    .inst_rd_en (inst_rd_en),
    .ir_wr_en   (ir_wr_en),
    .pc_wr_en   (pc_wr_en),
    .jump_en    (jump_en),
    .branch_en  (branch_en),
    .reg_wr_en  (reg_wr_en),
    .reg_dest   (reg_dest),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_to_reg (mem_to_reg),
    .alu_opcode (alu_opcode),
    .alu_in_sel (alu_in_sel),
    .instr_done (instr_done),
    .fault      (fault),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [17:0] IRD  = 18'h20000;
  localparam logic [17:0] IRW  = 18'h10000;
  localparam logic [17:0] PCW  = 18'h08000;
  localparam logic [17:0] JMP  = 18'h04000;
  localparam logic [17:0] BR   = 18'h02000;
  localparam logic [17:0] REGW = 18'h01000;
  localparam logic [17:0] DEST = 18'h00800;
  localparam logic [17:0] MRD  = 18'h00400;
  localparam logic [17:0] MWR  = 18'h00200;
  localparam logic [17:0] M2R  = 18'h00100;
  localparam logic [17:0] ASUB = 18'h00040;
  localparam logic [17:0] AFN  = 18'h00080;
  localparam logic [17:0] SEL  = 18'h00020;
  localparam logic [17:0] DONE = 18'h00010;
  localparam logic [17:0] FLT  = 18'h00008;
  localparam logic [17:0] ST0  = 18'h00000;
  localparam logic [17:0] ST1  = 18'h00001;
  localparam logic [17:0] ST2  = 18'h00002;
  localparam logic [17:0] ST3  = 18'h00003;
  localparam logic [17:0] ST4  = 18'h00004;
  localparam logic [17:0] ST5  = 18'h00005;
  localparam logic [17:0] ST7  = 18'h00007;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct {
    logic        rst;
    logic        run;
    logic [5:0]  op;
    logic        ir;
    logic        dr;
    logic [17:0] exp;
  } vec_t;

  vec_t tv[$];

  function automatic logic [17:0] outs();
    return {inst_rd_en, ir_wr_en, pc_wr_en, jump_en, branch_en, reg_wr_en,
            reg_dest, mem_rd_en, mem_wr_en, mem_to_reg, alu_opcode,
            alu_in_sel, instr_done, fault, state_dbg};
  endfunction

  task automatic add(input logic r, input logic rn, input logic [5:0] op,
                     input logic ir, input logic dr, input logic [17:0] e);
    vec_t v;
    v.rst = r; v.run = rn; v.op = op; v.ir = ir; v.dr = dr; v.exp = e;
    tv.push_back(v);
  endtask

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%05h expected=%05h", name, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset and R-type with both readies tied high.
    add(1'b1, 1'b1, OP_R,    1'b1, 1'b1, ST0);
    add(1'b1, 1'b1, OP_R,    1'b1, 1'b1, ST0);
    add(1'b0, 1'b1, OP_R,    1'b1, 1'b1, ST0);
    add(1'b0, 1'b1, OP_R,    1'b1, 1'b1, IRD | IRW | PCW | ST1);
    add(1'b0, 1'b1, OP_R,    1'b1, 1'b1, ST2);
    add(1'b0, 1'b1, OP_R,    1'b1, 1'b1, AFN | ST3);
    add(1'b0, 1'b1, OP_R,    1'b1, 1'b1, REGW | DEST | AFN | DONE | ST5);
    // lw with data_ready delayed 3 cycles: mem_rd_en held 4 cycles, 8 total.
    add(1'b0, 1'b1, OP_LW,   1'b1, 1'b0, IRD | IRW | PCW | ST1);
    add(1'b0, 1'b1, OP_LW,   1'b1, 1'b0, ST2);
    add(1'b0, 1'b1, OP_LW,   1'b1, 1'b0, SEL | ST3);
    add(1'b0, 1'b1, OP_LW,   1'b1, 1'b0, MRD | SEL | ST4);
    add(1'b0, 1'b1, OP_LW,   1'b1, 1'b0, MRD | SEL | ST4);
    add(1'b0, 1'b1, OP_LW,   1'b1, 1'b0, MRD | SEL | ST4);
    add(1'b0, 1'b1, OP_LW,   1'b1, 1'b1, MRD | SEL | ST4);
    add(1'b0, 1'b1, OP_LW,   1'b1, 1'b1, REGW | M2R | SEL | DONE | ST5);
    // beq (3 cycles), then j (2 cycles).
    add(1'b0, 1'b1, OP_BEQ,  1'b1, 1'b1, IRD | IRW | PCW | ST1);
    add(1'b0, 1'b1, OP_BEQ,  1'b1, 1'b1, ST2);
    add(1'b0, 1'b1, OP_BEQ,  1'b1, 1'b1, ASUB | BR | PCW | DONE | ST3);
    add(1'b0, 1'b1, OP_J,    1'b1, 1'b1, IRD | IRW | PCW | ST1);
    add(1'b0, 1'b1, OP_J,    1'b1, 1'b1, JMP | PCW | DONE | ST2);
    // addi with a two-cycle fetch wait; data_ready high but outside MEM.
    add(1'b0, 1'b1, OP_ADDI, 1'b0, 1'b1, IRD | ST1);
    add(1'b0, 1'b1, OP_ADDI, 1'b0, 1'b1, IRD | ST1);
    add(1'b0, 1'b1, OP_ADDI, 1'b1, 1'b1, IRD | IRW | PCW | ST1);
    add(1'b0, 1'b1, OP_ADDI, 1'b1, 1'b1, ST2);
    add(1'b0, 1'b1, OP_ADDI, 1'b1, 1'b1, SEL | ST3);
    add(1'b0, 1'b1, OP_ADDI, 1'b1, 1'b1, REGW | SEL | DONE | ST5);
    // sw with run dropped mid-instruction: it completes, then IDLE.
    add(1'b0, 1'b1, OP_SW,   1'b1, 1'b1, IRD | IRW | PCW | ST1);
    add(1'b0, 1'b1, OP_SW,   1'b1, 1'b0, ST2);
    add(1'b0, 1'b0, OP_SW,   1'b1, 1'b0, SEL | ST3);
    add(1'b0, 1'b0, OP_SW,   1'b1, 1'b0, MWR | SEL | ST4);
    add(1'b0, 1'b0, OP_SW,   1'b1, 1'b0, MWR | SEL | ST4);
    add(1'b0, 1'b0, OP_SW,   1'b1, 1'b1, MWR | SEL | DONE | ST4);
    add(1'b0, 1'b0, OP_SW,   1'b1, 1'b1, ST0);
    add(1'b0, 1'b0, OP_SW,   1'b1, 1'b1, ST0);
    add(1'b0, 1'b1, OP_BAD,  1'b1, 1'b1, ST0);
    // Illegal opcode: FAULT after DECODE, sticky until reset.
    add(1'b0, 1'b1, OP_BAD,  1'b1, 1'b1, IRD | IRW | PCW | ST1);
    add(1'b0, 1'b1, OP_BAD,  1'b1, 1'b1, ST2);
    add(1'b0, 1'b1, OP_R,    1'b1, 1'b1, FLT | ST7);
    add(1'b0, 1'b1, OP_R,    1'b1, 1'b1, FLT | ST7);
    add(1'b0, 1'b1, OP_LW,   1'b1, 1'b1, FLT | ST7);
    add(1'b1, 1'b1, OP_LW,   1'b1, 1'b1, FLT | ST7);
    add(1'b0, 1'b0, OP_LW,   1'b0, 1'b0, ST0);

    reset = 1'b1; run = 1'b1; opcode = OP_R; inst_ready = 1'b1; data_ready = 1'b1;
    @(posedge clk);

    for (int i = 0; i < tv.size(); i++) begin
      #1;
      reset = tv[i].rst; run = tv[i].run; opcode = tv[i].op;
      inst_ready = tv[i].ir; data_ready = tv[i].dr;
      @(negedge clk);
      check($sformatf("vec[%0d]", i), outs(), tv[i].exp);
      @(posedge clk);
    end
    #1;

    // Hand sequence: lw into MEM with data_ready held low.
    reset = 1'b0; run = 1'b1; opcode = OP_LW; inst_ready = 1'b1; data_ready = 1'b0;
    repeat (4) step();
    check("lw_mem_entry", outs(), MRD | SEL | ST4);
`ifdef MULTICYCLE_CONTROL_TIMEOUT_EN
    repeat (15) step();
    check("mem_wait15", outs(), MRD | SEL | ST4);
    step();
    check("mem_timeout", outs(), FLT | ST7);
`else
    repeat (20) step();
    check("mem_wait_unbounded", outs(), MRD | SEL | ST4);
`endif
    // Reset arriving during the wait (or from FAULT) clears everything.
    reset = 1'b1;
    step();
    check("reset_mid_wait", outs(), ST0);
    reset = 1'b0; run = 1'b0;
    step();
    check("idle_after_reset", outs(), ST0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so a stuck run still ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the CPU datapath: program counter, instruction memory, register file, ALU and data memory.
- Replaces single-cycle opcode decode with a state machine that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Waits on ready handshakes from instruction and data memory, so both can have variable latency.
- Flags illegal opcodes with a sticky fault state.

Parameters:
- TIMEOUT_CYCLES, 16: maximum wait cycles on a memory handshake. Used only when the optional feature is compiled in.
- TIMEOUT_W, 5: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- run  input  1  level; enables instruction sequencing
- opcode  input  6  opcode field from the instruction register
- inst_ready  input  1  instruction memory data valid
- data_ready  input  1  data memory read/write complete
- inst_rd_en  output  1  instruction fetch request
- ir_wr_en  output  1  load instruction register
- pc_wr_en  output  1  update program counter
- jump_en  output  1  PC source = jump address
- branch_en  output  1  PC source = branch address, qualified by the ALU zero flag
- reg_wr_en  output  1  register file write
- reg_dest  output  1  1 = rd field, 0 = rt field
- mem_rd_en  output  1  data memory read
- mem_wr_en  output  1  data memory write
- mem_to_reg  output  1  1 = write-back from memory, 0 = from ALU
- alu_opcode  output  2  00 add, 01 sub, 10 R-type funct, 11 unused
- alu_in_sel  output  1  1 = sign-extended immediate, 0 = register bus 2
- instr_done  output  1  one-cycle pulse on an instruction's last cycle
- fault  output  1  sticky illegal-opcode or timeout indication
- state_dbg  output  3  current state encoding

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7. State is registered.
- Outputs decode from state plus opcode_q (opcode latched in DECODE). Handshake-qualified outputs are noted where they occur.
- Reset: state=IDLE, opcode_q=0, fault=0; every output 0. Reset wins over all events, including mid-instruction and during memory waits.
- Legal opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000. Anything else is illegal.
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH:
  - inst_rd_en=1 while waiting.
  - When inst_ready=1, the same cycle asserts ir_wr_en=1 and pc_wr_en=1 (PC+4), then goes to DECODE.
  - Without inst_ready, stay in FETCH.
- DECODE:
  - Capture opcode into opcode_q.
  - Illegal opcode: go to FAULT.
  - j: jump_en=1, pc_wr_en=1, instr_done=1, then go to the boundary state.
  - Otherwise go to EXEC.
- EXEC:
  - R: alu_opcode=10, alu_in_sel=0, go to WB.
  - addi: alu_opcode=00, alu_in_sel=1, go to WB.
  - lw/sw: alu_opcode=00, alu_in_sel=1, go to MEM.
  - beq: alu_opcode=01, alu_in_sel=0, branch_en=1, pc_wr_en=1, instr_done=1, go to boundary. The PC module applies the branch only when zero_flag=1.
- MEM:
  - alu_opcode=00 and alu_in_sel=1 held throughout.
  - lw: mem_rd_en=1; on data_ready go to WB.
  - sw: mem_wr_en=1; on data_ready assert instr_done=1 and go to boundary.
  - Enables stay high until data_ready.
- WB:
  - Exactly one cycle: reg_wr_en=1.
  - reg_dest=1 for R, 0 otherwise; mem_to_reg=1 for lw only.
  - ALU controls match EXEC for R/addi.
  - instr_done=1, go to boundary.
- Boundary state: FETCH if run=1, else IDLE. run is sampled only at the boundary; deasserting run mid-instruction never aborts it.
- FAULT: all outputs 0 except fault=1. Stays in FAULT until reset.
- Latency in cycles, with zero-wait memory (ready high on the first request cycle): j=2, beq=3, R/addi=4, sw=4, lw=5.
- Simultaneous ready and a state change: ready is sampled only in its own waiting state; ready arriving in any other state is ignored.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W-bit counter clears on entry to FETCH and MEM and increments each wait cycle.
  - If the counter reaches TIMEOUT_CYCLES with no ready, go to FAULT.
  - Counter resets to 0.
- Not defined: no counter exists, and waits are unbounded.

Test Plan:
- Reset check: reset=1 for 2 cycles with run=1 -> all outputs 0, state_dbg=0. Release -> state_dbg=1 next cycle, inst_rd_en=1.
- R-type, ready tied high: opcode=000000 -> reg_wr_en=1 with reg_dest=1 and alu_opcode=10 in cycle 4, instr_done in the same cycle, then back to FETCH.
- lw with data_ready delayed 3 cycles: opcode=100011 -> mem_rd_en held 4 cycles, then WB with mem_to_reg=1, reg_dest=0, alu_in_sel=1; total 8 cycles.
- beq, then j: opcode=000100 -> branch_en=1 and alu_opcode=01 in cycle 3. opcode=000010 -> jump_en=1 and pc_wr_en=1 in cycle 2. No reg_wr_en or mem_wr_en in either.
- Illegal opcode 111111 -> FAULT after DECODE, fault=1, all enables 0; sticky until reset, and reset clears it.
- run dropped during MEM of sw: sw completes with mem_wr_en until data_ready, then state=IDLE. With MULTICYCLE_CONTROL_TIMEOUT_EN and data_ready held 0 -> fault=1 after 16 wait cycles.
